// File: rtl/wash_cycle_timer_if.sv
// rtl/wash_cycle_timer_if.sv - control/status bundle between the controller FSM and the phase timer
interface wash_cycle_timer_if #(
  parameter int DUR_W = 8
);
  logic [1:0]     clk_freq;
  logic           start;
  logic [DUR_W-1:0] duration;
  logic           double_time;
  logic           timer_pause;
  logic           abort;
  logic [DUR_W:0] remaining;
  logic           busy;
  logic           sec_tick;
  logic           timer_finish;

  modport slave (
    input  clk_freq, start, duration, double_time, timer_pause, abort,
    output remaining, busy, sec_tick, timer_finish
  );

  modport master (
    output clk_freq, start, duration, double_time, timer_pause, abort,
    input  remaining, busy, sec_tick, timer_finish
  );
endinterface

// File: rtl/wash_cycle_timer.sv
// rtl/wash_cycle_timer.sv - per-phase countdown with clock-scaled prescaler, pause, abort and restart
module wash_cycle_timer #(
  parameter int BASE_TICKS = 1_000_000,
  parameter int DUR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  wash_cycle_timer_if.slave bus
);
  localparam int CNT_W = $clog2(BASE_TICKS * 8);

  // Prescaler terminal values (P-1) for each clock scaling; P-1 always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] PM_X1 = CNT_W'(BASE_TICKS - 1);
  localparam logic [CNT_W-1:0] PM_X2 = CNT_W'(BASE_TICKS * 2 - 1);
  localparam logic [CNT_W-1:0] PM_X4 = CNT_W'(BASE_TICKS * 4 - 1);
  localparam logic [CNT_W-1:0] PM_X8 = CNT_W'(BASE_TICKS * 8 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pmax;
  logic [DUR_W:0]   r_rem;
  logic             r_busy;
  logic             r_tick;
  logic             r_fin;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_pmax_nxt;
  logic [DUR_W:0]   w_rem_nxt;
  logic             w_tick_nxt;
  logic             w_fin_nxt;
  logic [DUR_W:0]   w_eff;
  logic [CNT_W-1:0] w_pmax_sel;

  assign w_eff = bus.double_time ? {bus.duration, 1'b0} : {1'b0, bus.duration};

  always_comb begin
    w_pmax_sel = PM_X1;
    case (bus.clk_freq)
      2'd0:    w_pmax_sel = PM_X1;
      2'd1:    w_pmax_sel = PM_X2;
      2'd2:    w_pmax_sel = PM_X4;
      default: w_pmax_sel = PM_X8;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pmax_nxt  = r_pmax;
    w_rem_nxt   = r_rem;
    w_tick_nxt  = 1'b0;
    w_fin_nxt   = 1'b0;

    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_rem_nxt   = '0;
    end else if (bus.start) begin
      w_cnt_nxt = '0;
      if (w_eff == '0) begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = '0;
        w_fin_nxt   = 1'b1;
      end else begin
        w_state_nxt = ST_RUN;
        w_rem_nxt   = w_eff;
        w_pmax_nxt  = w_pmax_sel;
      end
    end else if (r_state != ST_IDLE) begin
      // The release cycle out of PAUSED counts, so each paused cycle costs exactly one cycle.
      if (bus.timer_pause) begin
        w_state_nxt = ST_PAUSED;
      end else begin
        w_state_nxt = ST_RUN;
        if (r_cnt == r_pmax) begin
          w_cnt_nxt  = '0;
          w_rem_nxt  = r_rem - (DUR_W+1)'(1);
          w_tick_nxt = 1'b1;
          if (r_rem == (DUR_W+1)'(1)) begin
            w_fin_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pmax  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pmax  <= w_pmax_nxt;
      r_rem   <= w_rem_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_tick  <= w_tick_nxt;
      r_fin   <= w_fin_nxt;
    end
  end

  assign bus.remaining    = r_rem;
  assign bus.busy         = r_busy;
  assign bus.sec_tick     = r_tick;
  assign bus.timer_finish = r_fin;
endmodule

// File: tb/tb_wash_cycle_timer.sv
// tb/tb_wash_cycle_timer.sv - directed scoreboard bench for wash_cycle_timer
module tb_wash_cycle_timer;
  localparam int BASE  = 4;
  localparam int DUR_W = 8;

  typedef struct {
    int             cyc;
    logic           tick;
    logic           fin;
    logic [DUR_W:0] rem;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

  wash_cycle_timer_if #(.DUR_W(DUR_W)) bus ();

  wash_cycle_timer #(.BASE_TICKS(BASE), .DUR_W(DUR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic t, input logic f, input int r);
    ev_t e;
    e.cyc  = c;
    e.tick = t;
    e.fin  = f;
    e.rem  = (DUR_W+1)'(r);
    exp_q.push_back(e);
  endtask

  // Expected ticks of a run of eff seconds with period p; ticks at or past
  // offset poff are pushed later by dly cycles (pause).
  task automatic push_run(input int e0, input int eff, input int p, input int poff, input int dly);
    for (int k = 1; k <= eff; k++) begin
      int c;
      c = e0 + k * p;
      if (dly > 0 && k * p >= poff) c = c + dly;
      push_ev(c, 1'b1, (k == eff), eff - k);
    end
  endtask

  task automatic start_run(input int dur, input logic dbl, input logic [1:0] f, output int e0);
    bus.duration    = DUR_W'(dur);
    bus.double_time = dbl;
    bus.clk_freq    = f;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (bus.sec_tick || bus.timer_finish) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'({bus.sec_tick, bus.timer_finish}), 0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_tick", int'(bus.sec_tick), int'(e.tick));
        chk("ev_finish", int'(bus.timer_finish), int'(e.fin));
        chk("ev_remaining", int'(bus.remaining), int'(e.rem));
      end
    end
  end

  initial begin
    int e0;
    int e1;
    checks = 0;
    errors = 0;
    rst_n           = 1'b0;
    bus.clk_freq    = 2'd0;
    bus.start       = 1'b0;
    bus.duration    = '0;
    bus.double_time = 1'b0;
    bus.timer_pause = 1'b0;
    bus.abort       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_remaining", int'(bus.remaining), 0);
    chk("reset_tick", int'(bus.sec_tick), 0);
    chk("reset_finish", int'(bus.timer_finish), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // pause while idle is ignored
    bus.timer_pause = 1'b1;
    repeat (3) @(negedge clk);
    bus.timer_pause = 1'b0;
    chk("idle_pause_busy", int'(bus.busy), 0);

    // basic run: 3 s at P=4
    start_run(3, 1'b0, 2'd0, e0);
    push_run(e0, 3, 4, 0, 0);
    chk("t1_busy", int'(bus.busy), 1);
    chk("t1_rem0", int'(bus.remaining), 3);
    wait_until(e0 + 5);
    chk("t1_rem_after1", int'(bus.remaining), 2);
    wait_until(e0 + 9);
    chk("t1_rem_after2", int'(bus.remaining), 1);
    wait_until(e0 + 11);
    chk("t1_busy_before_end", int'(bus.busy), 1);
    wait_until(e0 + 12);
    chk("t1_busy_end", int'(bus.busy), 0);
    chk("t1_rem_end", int'(bus.remaining), 0);
    repeat (2) @(negedge clk);

    // x2 clock, double time; mid-run input changes have no effect
    start_run(3, 1'b1, 2'd1, e0);
    push_run(e0, 6, 8, 0, 0);
    chk("t2_rem0", int'(bus.remaining), 6);
    bus.clk_freq    = 2'd0;
    bus.double_time = 1'b0;
    wait_until(e0 + 47);
    chk("t2_busy_before_end", int'(bus.busy), 1);
    wait_until(e0 + 48);
    chk("t2_finish", int'(bus.timer_finish), 1);
    chk("t2_busy_end", int'(bus.busy), 0);

    // back-to-back start while finish visible, then 5-cycle pause from E0+6
    start_run(3, 1'b0, 2'd0, e0);
    push_run(e0, 3, 4, 6, 5);
    chk("t3_rem0", int'(bus.remaining), 3);
    wait_until(e0 + 5);
    bus.timer_pause = 1'b1;
    wait_until(e0 + 8);
    chk("t3_rem_paused", int'(bus.remaining), 2);
    chk("t3_busy_paused", int'(bus.busy), 1);
    wait_until(e0 + 10);
    bus.timer_pause = 1'b0;
    wait_until(e0 + 12);
    chk("t3_rem_resumed", int'(bus.remaining), 2);
    wait_until(e0 + 16);
    chk("t3_busy_pre_end", int'(bus.busy), 1);
    wait_until(e0 + 17);
    chk("t3_busy_end", int'(bus.busy), 0);
    repeat (2) @(negedge clk);

    // abort mid-run
    start_run(5, 1'b0, 2'd0, e0);
    push_ev(e0 + 4, 1'b1, 1'b0, 4);
    push_ev(e0 + 8, 1'b1, 1'b0, 3);
    wait_until(e0 + 9);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t4_abort_busy", int'(bus.busy), 0);
    chk("t4_abort_rem", int'(bus.remaining), 0);
    repeat (40) @(negedge clk);

    // abort beats a simultaneous start
    bus.abort = 1'b1;
    start_run(5, 1'b0, 2'd0, e0);
    bus.abort = 1'b0;
    chk("t4_abort_start_busy", int'(bus.busy), 0);
    chk("t4_abort_start_rem", int'(bus.remaining), 0);
    @(negedge clk);

    // zero-length start
    push_ev(cyc + 1, 1'b0, 1'b1, 0);
    start_run(0, 1'b0, 2'd0, e0);
    chk("t4_zero_finish", int'(bus.timer_finish), 1);
    chk("t4_zero_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("t4_zero_finish_off", int'(bus.timer_finish), 0);
    chk("t4_zero_busy_after", int'(bus.busy), 0);

    // restart mid-run with a shorter duration
    start_run(4, 1'b0, 2'd0, e0);
    push_ev(e0 + 4, 1'b1, 1'b0, 3);
    push_ev(e0 + 8, 1'b1, 1'b0, 2);
    wait_until(e0 + 8);
    start_run(2, 1'b0, 2'd0, e1);
    push_run(e1, 2, 4, 0, 0);
    chk("t5_restart_cycle", e1, e0 + 9);
    chk("t5_restart_rem", int'(bus.remaining), 2);
    bus.clk_freq = 2'd3;
    wait_until(e1 + 7);
    chk("t5_busy_pre_end", int'(bus.busy), 1);
    wait_until(e1 + 8);
    chk("t5_busy_end", int'(bus.busy), 0);
    bus.clk_freq = 2'd0;
    repeat (10) @(negedge clk);

    // reset mid-run with start held during reset
    start_run(4, 1'b0, 2'd0, e0);
    push_ev(e0 + 4, 1'b1, 1'b0, 3);
    wait_until(e0 + 5);
    rst_n        = 1'b0;
    bus.duration = DUR_W'(9);
    bus.start    = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_rem", int'(bus.remaining), 0);
    chk("t6_rst_tick", int'(bus.sec_tick), 0);
    chk("t6_rst_finish", int'(bus.timer_finish), 0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("t6_after_rst_busy", int'(bus.busy), 0);
    repeat (30) @(negedge clk);
    chk("t6_late_busy", int'(bus.busy), 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wash_cycle_timer.md
# wash_cycle_timer

Programmable per-phase countdown timer for the washing-machine controller, replacing the fixed-duration timer. Accepts a per-phase duration in seconds from the controller FSM and scales it for the selected system clock frequency (1/2/4/8 × base) and optional double-time mode. Supports pause, abort and restart, and reports remaining seconds plus a per-second tick. Sits between the main control FSM and the front-panel display logic.

## Interface
- BASE_TICKS, 1_000_000 — clock cycles per second at clk_freq=2'b00; benches use small values such as 4.
- DUR_W, 8 — width of the duration input, in seconds.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- clk_freq  in  2  frequency select; prescale period P = BASE_TICKS << clk_freq; sampled only on an accepted start.
- start  in  1  single-cycle pulse; loads duration and begins counting.
- duration  in  DUR_W  phase length in seconds; sampled on start.
- double_time  in  1  sampled on start; effective length eff = duration*2 when set, else duration (DUR_W+1 bits, no overflow).
- timer_pause  in  1  level; freezes the count while high.
- abort  in  1  single-cycle pulse; cancels the run without a finish.
- remaining  out  DUR_W+1  whole seconds left.
- busy  out  1  high in RUN or PAUSED.
- sec_tick  out  1  one-cycle pulse per elapsed second.
- timer_finish  out  1  one-cycle pulse when the count reaches zero.

## Operation
- States: IDLE, RUN, PAUSED.
- Registers: prescaler cnt (clog2(BASE_TICKS*8) bits); latched P; remaining.
- Input priority each cycle: rst_n low > abort > start > timer_pause > counting.
- Reset: state IDLE; cnt, remaining, busy, sec_tick and timer_finish all 0.
- IDLE + start with eff>0: remaining<=eff, cnt<=0, latch P, go to RUN.
- IDLE + start with eff==0: stay IDLE; timer_finish pulses; remaining stays 0.
- RUN, timer_pause=0, cnt<P-1: cnt increments.
- RUN, timer_pause=0, cnt==P-1: cnt<=0, remaining decrements, sec_tick pulses. If remaining was 1, also pulse timer_finish and go to IDLE.
- RUN + timer_pause=1: go to PAUSED. cnt and remaining hold; the cycle spent entering PAUSED does not count.
- PAUSED + timer_pause=0: go to RUN. Counting resumes on the next cycle from the held cnt, so partial seconds are preserved.
- start in RUN or PAUSED: full reload as from IDLE (restart). No finish is emitted for the cancelled run.
- abort in any state: go to IDLE, remaining<=0, cnt<=0, no finish. abort wins over a simultaneous start.
- timer_pause in IDLE: ignored.
- clk_freq or double_time changes mid-run: no effect until the next start.

## Timing
- All outputs are registered.
- Let edge E0 be the edge that samples start. After E0: busy=1, remaining=eff, cnt=0.
- With no pause, sec_tick k is visible after edge E0 + k·P. remaining = eff−k from that edge.
- timer_finish is visible for exactly one cycle after edge E0 + eff·P, coincident with the last sec_tick, remaining=0 and busy=0.
- Each cycle timer_pause is high during RUN/PAUSED extends the finish by exactly one cycle.
- Zero-length start: timer_finish visible for one cycle after E0; busy never rises.
- Reset mid-run: all outputs are 0 after the reset edge and no finish fires later. rst_n held low ignores start.
- Back-to-back: a start in the cycle timer_finish is visible is accepted normally.

## Test plan
- BASE_TICKS=4, clk_freq=00, duration=3, double_time=0 -> sec_tick at E0+4, +8, +12. remaining steps 3,2,1,0. timer_finish single pulse at E0+12; busy low from E0+12.
- BASE_TICKS=4, clk_freq=01, duration=3, double_time=1 -> P=8, eff=6, remaining starts at 6, timer_finish at E0+48.
- duration=3, clk_freq=00, timer_pause high for 5 cycles starting at E0+6 -> remaining frozen at 2 throughout the pause, timer_finish at E0+17, no extra sec_tick.
- Run duration=5; abort at E0+10 -> busy=0 and remaining=0 next cycle, no timer_finish within the following 40 cycles. Then start with duration=0 -> one-cycle timer_finish, busy stays 0.
- Run duration=4; at E0+9 pulse start with duration=2 -> remaining=2 after that edge, timer_finish at (E0+9)+8, exactly one finish overall. Change clk_freq mid-run -> period unchanged.
- Run duration=4; drive rst_n low for 1 cycle at E0+6 -> all outputs 0 after that edge, no finish afterwards. A start held during reset is ignored.
